// File: rtl/imem_loader_pkg.sv
// ============================================================================
//  Module      : imem_loader_pkg
//  Description : Shared sizes, limits and FSM state encoding for the
//                instruction-memory loader. Optional checksum feature is
//                enabled with the IMEM_LOADER_CSUM_EN macro.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imem_loader_pkg;

  localparam int ADDR_W = 7;   // instruction memory address width (PC width)
  localparam int DATA_W = 16;  // instruction word width (IR width)
  localparam int DEPTH  = 128; // number of instruction words
  localparam int LEN_W  = 8;   // width of the host word-count field

  // Largest word count a Start may request.
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CSUM  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/imem_loader_if.sv
// ============================================================================
//  Module      : imem_loader_if
//  Description : Host stream, control and instruction-memory write bus of the
//                loader. master = host/processor side, slave = loader.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface imem_loader_if;
  import imem_loader_pkg::*;

  logic              Start;
  logic [LEN_W-1:0]  Len;
  logic              Abort;
  logic [DATA_W-1:0] In_Data;
  logic              In_Valid;
  logic              In_Ready;
  logic              Mem_Wr;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [DATA_W-1:0] Mem_Data;
  logic              Cpu_Hold;
  logic              Busy;
  logic              Done;
  logic              Err;

  modport master (
    output Start, Len, Abort, In_Data, In_Valid,
    input  In_Ready, Mem_Wr, Mem_Addr, Mem_Data, Cpu_Hold, Busy, Done, Err
  );

  modport slave (
    input  Start, Len, Abort, In_Data, In_Valid,
    output In_Ready, Mem_Wr, Mem_Addr, Mem_Data, Cpu_Hold, Busy, Done, Err
  );

endinterface

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
//  Module      : imem_loader
//  Description : Writes a host-supplied program into instruction memory from
//                address 0 while holding the processor in reset, then
//                releases it one cycle after the final write.
//                Define IMEM_LOADER_CSUM_EN to require a trailing 16-bit
//                checksum word (sum mod 2^16 of the program words).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader
  import imem_loader_pkg::*;
(
  input  logic         Clk,
  input  logic         Reset,
  imem_loader_if.slave bus
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] count, count_nxt;
  logic [LEN_W-1:0]  len_q, len_nxt;
  logic              mem_wr, mem_wr_nxt;
  logic [ADDR_W-1:0] mem_addr, mem_addr_nxt;
  logic [DATA_W-1:0] mem_data, mem_data_nxt;
  logic              hold, hold_nxt;
  logic              busy, busy_nxt;
  logic              done, done_nxt;
  logic              err, err_nxt;

  logic              in_ready;
  logic              beat;
  logic              last_beat;
  logic              start_ok;
  logic [LEN_W-1:0]  last_idx;

`ifdef IMEM_LOADER_CSUM_EN
  logic [DATA_W-1:0] sum, sum_nxt;
`endif

  // Ready is a pure decode of the state register so it never depends on inputs.
  assign in_ready  = (state == LOAD) || (state == CSUM);
  assign beat      = bus.In_Valid && in_ready;
  assign last_idx  = len_q - LEN_W'(1);
  assign last_beat = (LEN_W'(count) == last_idx);
  assign start_ok  = (bus.Len != '0) && (bus.Len <= LEN_MAX);

  // State, counter and all registered outputs; reset clears everything at once.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      count    <= '0;
      len_q    <= '0;
      mem_wr   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      hold     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      len_q    <= len_nxt;
      mem_wr   <= mem_wr_nxt;
      mem_addr <= mem_addr_nxt;
      mem_data <= mem_data_nxt;
      hold     <= hold_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
    end
  end

`ifdef IMEM_LOADER_CSUM_EN
  // Running checksum of accepted program words.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) sum <= '0;
    else        sum <= sum_nxt;
  end
`endif

  // Next-state and next-output decode; Abort outranks a same-cycle beat.
  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    len_nxt      = len_q;
    mem_wr_nxt   = 1'b0;
    mem_addr_nxt = mem_addr;
    mem_data_nxt = mem_data;
    hold_nxt     = hold;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
    sum_nxt      = sum;
`endif

    case (state)
      IDLE: begin
        if (bus.Start) begin
          if (start_ok) begin
            len_nxt   = bus.Len;
            count_nxt = '0;
            hold_nxt  = 1'b1;
            state_nxt = LOAD;
`ifdef IMEM_LOADER_CSUM_EN
            sum_nxt   = '0;
`endif
          end else begin
            err_nxt = 1'b1;
          end
        end
      end

      LOAD: begin
        if (bus.Abort) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else if (beat) begin
          mem_wr_nxt   = 1'b1;
          mem_addr_nxt = count;
          mem_data_nxt = bus.In_Data;
          count_nxt    = count + 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
          sum_nxt      = sum + bus.In_Data;
          if (last_beat) state_nxt = CSUM;
`else
          if (last_beat) state_nxt = DRAIN;
`endif
        end
      end

`ifdef IMEM_LOADER_CSUM_EN
      CSUM: begin
        if (bus.Abort) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else if (beat) begin
          // The checksum word is compared only, never written to memory.
          if (bus.In_Data == sum) begin
            state_nxt = DRAIN;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
`endif

      DRAIN: begin
        if (bus.Abort) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          done_nxt  = 1'b1;
          hold_nxt  = 1'b0;
          state_nxt = DONE;
        end
      end

      DONE: begin
        err_nxt   = bus.Abort;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  assign bus.In_Ready = in_ready;
  assign bus.Mem_Wr   = mem_wr;
  assign bus.Mem_Addr = mem_addr;
  assign bus.Mem_Data = mem_data;
  assign bus.Cpu_Hold = hold;
  assign bus.Busy     = busy;
  assign bus.Done     = done;
  assign bus.Err      = err;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Directed vector bench for imem_loader. Each table row is one
//                clock: inputs driven before the edge, outputs compared 1 ns
//                after it. Define IMEM_LOADER_CSUM_EN for the checksum build.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;
  import imem_loader_pkg::*;

  typedef struct packed {
    logic              rdy;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              hold;
    logic              busy;
    logic              done;
    logic              err;
  } exp_t;

  typedef struct packed {
    logic              st;
    logic [LEN_W-1:0]  ln;
    logic              ab;
    logic              vl;
    logic [DATA_W-1:0] d;
    exp_t              e;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  vec_t vq[$];

  imem_loader_if bus();

  imem_loader dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Append one row: inputs for the cycle, then the outputs expected after the edge.
  task automatic add(input logic st, input logic [LEN_W-1:0] ln, input logic ab,
                     input logic vl, input logic [DATA_W-1:0] d,
                     input logic rdy, input logic wr, input logic [ADDR_W-1:0] ad,
                     input logic [DATA_W-1:0] wd, input logic hold, input logic busy,
                     input logic done, input logic err);
    vec_t v;
    v.st = st; v.ln = ln; v.ab = ab; v.vl = vl; v.d = d;
    v.e.rdy = rdy; v.e.wr = wr; v.e.addr = ad; v.e.wdata = wd;
    v.e.hold = hold; v.e.busy = busy; v.e.done = done; v.e.err = err;
    vq.push_back(v);
  endtask

  task automatic drive(input logic st, input logic [LEN_W-1:0] ln, input logic ab,
                       input logic vl, input logic [DATA_W-1:0] d);
    bus.Start = st; bus.Len = ln; bus.Abort = ab; bus.In_Valid = vl; bus.In_Data = d;
  endtask

  // Address/data are only meaningful with a write, unless full is set.
  task automatic check(input string nm, input exp_t e, input bit full);
    exp_t a;
    bit   bad;
    a.rdy = bus.In_Ready; a.wr = bus.Mem_Wr; a.addr = bus.Mem_Addr;
    a.wdata = bus.Mem_Data; a.hold = bus.Cpu_Hold; a.busy = bus.Busy;
    a.done = bus.Done; a.err = bus.Err;
    bad = (a.rdy != e.rdy) || (a.wr != e.wr) || (a.hold != e.hold) ||
          (a.busy != e.busy) || (a.done != e.done) || (a.err != e.err);
    if (e.wr || full)
      bad = bad || (a.addr != e.addr) || (a.wdata != e.wdata);
    n_vec++;
    if (bad) begin
      n_bad++;
      $display("FAIL %s: got rdy=%b wr=%b addr=%0d data=%h hold=%b busy=%b done=%b err=%b ; want rdy=%b wr=%b addr=%0d data=%h hold=%b busy=%b done=%b err=%b",
               nm, a.rdy, a.wr, a.addr, a.wdata, a.hold, a.busy, a.done, a.err,
               e.rdy, e.wr, e.addr, e.wdata, e.hold, e.busy, e.done, e.err);
    end
  endtask

  function automatic exp_t mk(input logic rdy, input logic wr, input logic [ADDR_W-1:0] ad,
                              input logic [DATA_W-1:0] wd, input logic hold,
                              input logic busy, input logic done, input logic err);
    exp_t e;
    e.rdy = rdy; e.wr = wr; e.addr = ad; e.wdata = wd;
    e.hold = hold; e.busy = busy; e.done = done; e.err = err;
    return e;
  endfunction

  initial begin
    bit seen;
    drive(0, 0, 0, 0, 0);

    // ---------------- vector table ----------------
`ifdef IMEM_LOADER_CSUM_EN
    // Words 1,2,3 with correct checksum 6.
    add(1, 3, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 1, 1, 0, 0);
    add(0, 0, 0, 1, 16'h0001, 1, 1, 0, 16'h0001, 1, 1, 0, 0);
    add(0, 0, 0, 1, 16'h0002, 1, 1, 1, 16'h0002, 1, 1, 0, 0);
    add(0, 0, 0, 1, 16'h0003, 1, 1, 2, 16'h0003, 1, 1, 0, 0);
    add(0, 0, 0, 1, 16'h0006, 0, 0, 0, 16'h0000, 1, 1, 0, 0);
    add(0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 1, 1, 0);
    add(0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
`else
    // Len=3 back-to-back.
    add(1, 3, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 1, 1, 0, 0);
    add(0, 0, 0, 1, 16'h1234, 1, 1, 0, 16'h1234, 1, 1, 0, 0);
    add(0, 0, 0, 1, 16'hABCD, 1, 1, 1, 16'hABCD, 1, 1, 0, 0);
    add(0, 0, 0, 1, 16'h0F0F, 0, 1, 2, 16'h0F0F, 1, 1, 0, 0);
    add(0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 1, 1, 0);
    add(0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
    // Len=2 with two idle cycles between words.
    add(1, 2, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 1, 1, 0, 0);
    add(0, 0, 0, 1, 16'h1111, 1, 1, 0, 16'h1111, 1, 1, 0, 0);
    add(0, 0, 0, 0, 16'hDEAD, 1, 0, 0, 16'h0000, 1, 1, 0, 0);
    add(0, 0, 0, 0, 16'hDEAD, 1, 0, 0, 16'h0000, 1, 1, 0, 0);
    add(0, 0, 0, 1, 16'h2222, 0, 1, 1, 16'h2222, 1, 1, 0, 0);
    add(0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 1, 1, 0);
    add(0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
`endif
    // Rejected starts: Len=0 and Len=129.
    add(1, 0,   0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 1);
    add(0, 0,   0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
    add(1, 129, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 1);
    add(0, 0,   0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
    // Len=128 is accepted; abort right away leaves Cpu_Hold set.
    add(1, 128, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 1, 1, 0, 0);
    add(0, 0,   1, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 0, 1);
    // Len=4 aborted after two words; the abort-cycle beat is dropped.
    add(1, 4, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 1, 1, 0, 0);
    add(0, 0, 0, 1, 16'hA000, 1, 1, 0, 16'hA000, 1, 1, 0, 0);
    add(0, 0, 0, 1, 16'hA001, 1, 1, 1, 16'hA001, 1, 1, 0, 0);
    add(0, 0, 1, 1, 16'hA002, 0, 0, 0, 16'h0000, 1, 0, 0, 1);
    add(0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 0, 0);
    // Abort in IDLE is ignored.
    add(0, 0, 1, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 0, 0);
`ifdef IMEM_LOADER_CSUM_EN
    // Words 1,2,3 with bad checksum 7: no write of the checksum word.
    add(1, 3, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 1, 1, 0, 0);
    add(0, 0, 0, 1, 16'h0001, 1, 1, 0, 16'h0001, 1, 1, 0, 0);
    add(0, 0, 0, 1, 16'h0002, 1, 1, 1, 16'h0002, 1, 1, 0, 0);
    add(0, 0, 0, 1, 16'h0003, 1, 1, 2, 16'h0003, 1, 1, 0, 0);
    add(0, 0, 0, 1, 16'h0007, 0, 0, 0, 16'h0000, 1, 0, 0, 1);
    add(0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 0, 0);
    // Good Len=1 load clears the hold; Start inside LOAD is ignored.
    add(1, 1, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 1, 1, 0, 0);
    add(1, 0, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 1, 1, 0, 0);
    add(0, 0, 0, 1, 16'hB0B0, 1, 1, 0, 16'hB0B0, 1, 1, 0, 0);
    add(0, 0, 0, 1, 16'hB0B0, 0, 0, 0, 16'h0000, 1, 1, 0, 0);
`else
    // Good Len=1 load clears the hold; Start inside LOAD is ignored.
    add(1, 1, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 1, 1, 0, 0);
    add(1, 0, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 1, 1, 0, 0);
    add(0, 0, 0, 1, 16'hB0B0, 0, 1, 0, 16'hB0B0, 1, 1, 0, 0);
`endif
    add(0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 1, 1, 0);
    add(0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
    // Len=8 load stopped at count 5 (async reset follows).
    add(1, 8, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++)
      add(0, 0, 0, 1, 16'hC000 + 16'(i), 1, 1, 7'(i), 16'hC000 + 16'(i), 1, 1, 0, 0);

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    check("reset", mk(0, 0, 0, 16'h0000, 0, 0, 0, 0), 1'b1);
    rst_n = 1'b1;

    // ---------------- apply table ----------------
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].st, vq[i].ln, vq[i].ab, vq[i].vl, vq[i].d);
      @(posedge clk);
      #1;
      check($sformatf("vec[%0d]", i), vq[i].e, 1'b0);
    end
    drive(0, 0, 0, 0, 0);

    // ---------------- async reset mid-load ----------------
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", mk(0, 0, 0, 16'h0000, 0, 0, 0, 0), 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // New load must restart at address 0.
    drive(1, 2, 0, 0, 0);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 1, 16'hD001);
    @(posedge clk);
    #1;
    check("restart_addr0", mk(1, 1, 0, 16'hD001, 1, 1, 0, 0), 1'b0);
    drive(0, 0, 0, 1, 16'hD002);
    @(posedge clk);
    #1;
`ifdef IMEM_LOADER_CSUM_EN
    drive(0, 0, 0, 1, 16'hA003);
    @(posedge clk);
    #1;
`endif
    drive(0, 0, 0, 0, 0);

    // Bounded wait for the completion pulse.
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (bus.Done) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    n_vec++;
    if (!seen) begin
      n_bad++;
      $display("FAIL restart_done: got no Done within 10 cycles, want one Done pulse");
    end else begin
      check("restart_done", mk(0, 0, 0, 16'h0000, 0, 1, 1, 0), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the processor's instruction memory: the processor reads instruction words at PC, and this block writes them.
- Accepts a stream of 16-bit instruction words from a host over a valid/ready handshake and writes them sequentially from address 0.
- Holds the processor in reset for the whole load, then releases it so execution restarts at PC 0 with the new program.

Parameters:
- ADDR_W, 7, instruction memory address width (matches PC width).
- DATA_W, 16, instruction word width (matches IR width).
- DEPTH, 128, number of instruction words; Len must be in 1..DEPTH.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  one-cycle pulse that requests a load of Len words.
- Len  input  8  word count, sampled only on an accepted Start.
- Abort  input  1  cancels a load in progress.
- In_Data  input  DATA_W  instruction word from the host.
- In_Valid  input  1  In_Data is valid.
- In_Ready  output  1  loader accepts a word this cycle.
- Mem_Wr  output  1  instruction memory write strobe.
- Mem_Addr  output  ADDR_W  instruction memory write address.
- Mem_Data  output  DATA_W  instruction memory write data.
- Cpu_Hold  output  1  high holds the processor in reset.
- Busy  output  1  high in every state except IDLE.
- Done  output  1  one-cycle pulse on successful completion.
- Err  output  1  one-cycle pulse on a rejected Start, an Abort, or a checksum failure.

Behaviour:
- Reset (Reset=0, asynchronous): state IDLE; count 0; Mem_Wr, Mem_Addr, Mem_Data, Cpu_Hold, Busy, Done, Err all 0. In_Ready is 0.
- All outputs except In_Ready are registered. In_Ready = (state==LOAD) || (state==CSUM), decoded from the state register only.
- States: IDLE, LOAD, DRAIN, DONE, plus CSUM when the optional feature is compiled in.
- IDLE:
  - Start with 1<=Len<=DEPTH: latch Len, clear count, set Cpu_Hold=1, go to LOAD.
  - Start with Len==0 or Len>DEPTH: Err=1 for one cycle; stay in IDLE; Cpu_Hold unchanged.
- Start outside IDLE is ignored.
- LOAD:
  - A beat is accepted when In_Valid && In_Ready.
  - Next cycle after each beat: Mem_Wr=1, Mem_Addr=count, Mem_Data=In_Data (write latency 1 cycle). count increments.
  - Mem_Wr is 0 on every cycle with no beat. Back-to-back beats produce back-to-back writes.
  - When the accepted beat is word Len-1: go to DRAIN (or CSUM if enabled).
- DRAIN: lasts one cycle, during which the final write is presented. In_Ready=0. Go to DONE.
- DONE: lasts one cycle. Done=1, Cpu_Hold=0, go to IDLE. The processor therefore leaves reset exactly one cycle after the last Mem_Wr.
- Abort in any non-IDLE state: go to IDLE the next cycle. Err=1 for one cycle. Any write already registered still completes. Cpu_Hold stays 1, because the program is partial; it is cleared only by a later successful load.
- Abort in IDLE is ignored. Abort takes priority over a beat accepted in the same cycle: that beat is not written.
- Address wrap cannot occur: count never exceeds Len-1 <= DEPTH-1.
- Reset asserted mid-load: immediate return to IDLE with all outputs 0. Any partial program is left in memory.

Optional Feature:
- Macro: IMEM_LOADER_CSUM_EN.
- With the macro defined:
  - A 16-bit running sum (mod 2^16) of accepted data words is kept, cleared on an accepted Start.
  - After word Len-1 the FSM enters CSUM with In_Ready=1 and accepts one extra word; this word is never written to memory.
  - Checksum word equals the sum: go to DRAIN, then DONE as normal.
  - Mismatch: Err pulse, go to IDLE, Cpu_Hold stays 1.
  - Abort in CSUM behaves as in LOAD.
- Without the macro: no CSUM state and no accumulator. LOAD goes directly to DRAIN.

Decomposition:
- Package imem_loader_pkg holds:
  - ADDR_W, DATA_W, DEPTH;
  - the state enum (IDLE, LOAD, CSUM, DRAIN, DONE) as logic [2:0];
  - the LEN_MAX constant.
- No sub-module is required. The FSM and counter live in one module.
- The checksum accumulator is inline under the macro and is not split out.

Test Plan:
- Reset, then Start with Len=3; words 16'h1234, 16'hABCD, 16'h0F0F sent back-to-back -> Mem_Wr high on 3 consecutive cycles at addresses 0,1,2 with matching data; Cpu_Hold falls one cycle after the last write; one Done pulse.
- Len=2 with In_Valid gaps of 2 cycles between words -> exactly 2 writes with no spurious Mem_Wr; In_Ready held high throughout LOAD.
- Start with Len=0, then Start with Len=129 -> two Err pulses, Busy stays 0, no writes.
- Len=4 with Abort asserted after 2 accepted words -> writes only to addresses 0 and 1; Err pulse; state IDLE; Cpu_Hold stays 1; a following good load then clears it.
- Reset pulled low while in LOAD at count 5 -> all outputs 0 immediately; a new Start begins again at address 0.
- With IMEM_LOADER_CSUM_EN: words 1,2,3 then checksum 6 -> Done pulse; same words with checksum 7 -> Err pulse, Cpu_Hold stays 1, no memory write for the checksum word.
